mem_arbiter: RTL

Sequencer that shares one unified, clocked single-port word memory between the instruction-fetch port and the load/store data port of the multi-cycle core. Each cycle it accepts at most one request, drives the memory's enable, write and address lines, and routes the one-cycle-latency read data back to the requester that issued the read. Out-of-range accesses are trapped here: they are not sent to the memory and are flagged to the core.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, one-cycle-latency word memory between
// the instruction-fetch port and the load/store data port.
// Two-state sequencer: IDLE grants one request per cycle, RESP returns read data.
// Out-of-range word indices never reach the memory; they pulse err instead.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed
// data-over-fetch priority.
module mem_arbiter #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          err
);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    localparam logic SRC_FETCH = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    state_t r_state;
    state_t w_state_next;
    logic   r_src;
    logic   w_src_next;
    logic   r_rd_oor;
    logic   w_rd_oor_next;

    logic   w_d_inr;
    logic   w_if_inr;
    logic   w_d_prio;
    logic   w_pick_d;
    logic   w_unused_bits;

    // Byte-offset bits play no part in word addressing.
    assign w_unused_bits = ^{if_addr[1:0], d_addr[1:0]};

    // Word index must fall inside the memory.
    assign w_d_inr  = ({2'b00, d_addr[31:2]}  < 32'(MEM_WORDS));
    assign w_if_inr = ({2'b00, if_addr[31:2]} < 32'(MEM_WORDS));

`ifdef MEM_ARB_RR_EN
    logic r_last;

    // Data wins a conflict only if fetch won the previous grant.
    assign w_d_prio = (r_last == SRC_FETCH);

    // Remember which port was granted most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= SRC_FETCH;
        end else if (d_gnt) begin
            r_last <= SRC_DATA;
        end else if (if_gnt) begin
            r_last <= SRC_FETCH;
        end
    end
`else
    assign w_d_prio = 1'b1;
`endif

    // Data is picked when it is alone or has priority over a competing fetch.
    assign w_pick_d = d_req && (!if_req || w_d_prio);

    // State, read-source and read-trap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_src    <= SRC_FETCH;
            r_rd_oor <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_src    <= w_src_next;
            r_rd_oor <= w_rd_oor_next;
        end
    end

    // Next state, grants, memory strobes and read-data routing.
    always_comb begin
        w_state_next  = r_state;
        w_src_next    = r_src;
        w_rd_oor_next = r_rd_oor;
        if_gnt        = 1'b0;
        if_rvalid     = 1'b0;
        if_rdata      = 32'd0;
        d_gnt         = 1'b0;
        d_rvalid      = 1'b0;
        d_rdata       = 32'd0;
        mem_en        = 1'b0;
        mem_we        = 4'd0;
        mem_addr      = '0;
        mem_wdata     = 32'd0;
        err           = 1'b0;

        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_d) begin
                        d_gnt = 1'b1;
                        if (w_d_inr) begin
                            mem_en    = 1'b1;
                            mem_addr  = d_addr[AW+1:2];
                            mem_wdata = d_wdata;
                            mem_we    = d_we ? d_be : 4'd0;
                        end
                        if (d_we) begin
                            // Stores finish in the grant cycle.
                            err = !w_d_inr;
                        end else begin
                            w_state_next  = S_RESP;
                            w_src_next    = SRC_DATA;
                            w_rd_oor_next = !w_d_inr;
                        end
                    end else if (if_req) begin
                        if_gnt = 1'b1;
                        if (w_if_inr) begin
                            mem_en   = 1'b1;
                            mem_addr = if_addr[AW+1:2];
                        end
                        w_state_next  = S_RESP;
                        w_src_next    = SRC_FETCH;
                        w_rd_oor_next = !w_if_inr;
                    end
                end
                S_RESP: begin
                    // A trapped read returns zero and flags err.
                    if (r_src == SRC_DATA) begin
                        d_rvalid = 1'b1;
                        d_rdata  = r_rd_oor ? 32'd0 : mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = r_rd_oor ? 32'd0 : mem_rdata;
                    end
                    err          = r_rd_oor;
                    w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

endmodule
